// File: rtl/cp0_unit_if.sv
// Bundle of decode strobes, mfc0 read data and fetch redirect signals for cp0_unit.
// No latency of its own; pure wiring between the core and the CP0 block.
// No backpressure: every strobe is consumed in the cycle it is presented.
//
// Signals (driven by the core side = master, consumed by cp0_unit = slave):
//   i_valid, i_pc_next, i_mtc0, i_eret, i_cp0_addr, i_cp0_wdata, i_irq  -> cp0_unit
//   o_cp0_rdata, o_redirect, o_redirect_pc, o_int_taken                 <- cp0_unit
interface cp0_unit_if #(
    parameter int IRQ_W = 6
);
    logic              i_valid;
    logic [31:0]       i_pc_next;
    logic              i_mtc0;
    logic              i_eret;
    logic [4:0]        i_cp0_addr;
    logic [31:0]       i_cp0_wdata;
    logic [IRQ_W-1:0]  i_irq;
    logic [31:0]       o_cp0_rdata;
    logic              o_redirect;
    logic [31:0]       o_redirect_pc;
    logic              o_int_taken;

    modport master (
        output i_valid, i_pc_next, i_mtc0, i_eret, i_cp0_addr, i_cp0_wdata, i_irq,
        input  o_cp0_rdata, o_redirect, o_redirect_pc, o_int_taken
    );

    modport slave (
        input  i_valid, i_pc_next, i_mtc0, i_eret, i_cp0_addr, i_cp0_wdata, i_irq,
        output o_cp0_rdata, o_redirect, o_redirect_pc, o_int_taken
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0: Status/Cause/EPC/Count/Compare, interrupt arbitration and PC redirect.
// Reads and redirect outputs are combinational; state updates at the next rising edge;
// external IRQs reach Cause.IP three edges after assertion (2 sync flops + IP register).
// No backpressure: mtc0/eret/interrupt entry complete in the cycle i_valid is high.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   cp0         slave side of cp0_unit_if (decode strobes in, read data / redirect out)
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0800,
    parameter int          IRQ_W      = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    cp0_unit_if.slave  cp0
);

    // Register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    // Bit position of the lowest interrupt line within Status.IM / Cause.IP
    localparam int IP_LSB = 10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IRQ_W-1:0] irq_meta;     // first synchroniser stage
    logic [IRQ_W-1:0] irq_s;        // synchronised interrupt levels
    logic [IRQ_W-1:0] ip;           // Cause.IP
    logic             ti;           // Cause.TI (sticky timer interrupt)
    logic [31:0]      count;
    logic [31:0]      compare;
    logic [IRQ_W-1:0] im;           // Status.IM
    logic             exl;          // Status.EXL
    logic             ie;           // Status.IE
    logic [31:0]      epc;

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    logic pend;
    logic take_eret;
    logic do_mtc0;
    logic take_int;
    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_epc;
    logic timer_hit;
    logic [IRQ_W-1:0] ip_next;

    // Pending is computed purely from registered state so that an mtc0 in the
    // same cycle cannot create or cancel an interrupt combinationally.
    assign pend = ie & ~exl & (|(ip & im));

    // eret beats mtc0 beats interrupt entry; nothing happens without i_valid.
    always_comb begin
        take_eret = 1'b0;
        do_mtc0   = 1'b0;
        take_int  = 1'b0;
        if (cp0.i_valid) begin
            if (cp0.i_eret) begin
                take_eret = 1'b1;
            end else if (cp0.i_mtc0) begin
                do_mtc0 = 1'b1;
            end else if (pend) begin
                take_int = 1'b1;
            end
        end
    end

    assign wr_count   = do_mtc0 && (cp0.i_cp0_addr == ADDR_COUNT);
    assign wr_compare = do_mtc0 && (cp0.i_cp0_addr == ADDR_COMPARE);
    assign wr_status  = do_mtc0 && (cp0.i_cp0_addr == ADDR_STATUS);
    assign wr_epc     = do_mtc0 && (cp0.i_cp0_addr == ADDR_EPC);

    // Compare==0 disables the timer so that a cleared Compare cannot re-arm TI.
    assign timer_hit = (count == compare) && (compare != 32'd0);

    // The timer shares the top interrupt line with the last external IRQ.
    always_comb begin
        ip_next              = irq_s;
        ip_next[IRQ_W-1]     = irq_s[IRQ_W-1] | ti;
    end

    // ------------------------------------------------------------------
    // Interrupt synchroniser, Cause.IP and timer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            irq_meta <= '0;
            irq_s    <= '0;
            ip       <= '0;
        end else begin
            irq_meta <= cp0.i_irq;
            irq_s    <= irq_meta;
            ip       <= ip_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            // Software write to Count replaces this cycle's increment.
            if (wr_count) begin
                count <= cp0.i_cp0_wdata;
            end else begin
                count <= count + 32'd1;
            end

            if (wr_compare) begin
                compare <= cp0.i_cp0_wdata;
            end

            // Acknowledge (write to Compare) wins over a coincident match.
            if (wr_compare) begin
                ti <= 1'b0;
            end else if (timer_hit) begin
                ti <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status and EPC
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            im  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
        end else begin
            if (take_eret) begin
                exl <= 1'b0;
            end else if (wr_status) begin
                im  <= cp0.i_cp0_wdata[IP_LSB +: IRQ_W];
                exl <= cp0.i_cp0_wdata[1];
                ie  <= cp0.i_cp0_wdata[0];
            end else if (take_int) begin
                exl <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            epc <= 32'd0;
        end else begin
            if (wr_epc) begin
                epc <= cp0.i_cp0_wdata;
            end else if (take_int) begin
                // Return to the instruction that would have executed next.
                epc <= cp0.i_pc_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // mfc0 read mux
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] cause_word;

    always_comb begin
        status_word                   = 32'd0;
        status_word[IP_LSB +: IRQ_W]  = im;
        status_word[1]                = exl;
        status_word[0]                = ie;

        cause_word                    = 32'd0;
        cause_word[30]                = ti;
        cause_word[IP_LSB +: IRQ_W]   = ip;
    end

    always_comb begin
        cp0.o_cp0_rdata = 32'd0;
        case (cp0.i_cp0_addr)
            ADDR_COUNT:   cp0.o_cp0_rdata = count;
            ADDR_COMPARE: cp0.o_cp0_rdata = compare;
            ADDR_STATUS:  cp0.o_cp0_rdata = status_word;
            ADDR_CAUSE:   cp0.o_cp0_rdata = cause_word;
            ADDR_EPC:     cp0.o_cp0_rdata = epc;
            default:      cp0.o_cp0_rdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch redirect (suppressed while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        cp0.o_redirect    = ~i_rst & (take_eret | take_int);
        cp0.o_int_taken   = ~i_rst & take_int;
        cp0.o_redirect_pc = take_eret ? epc : EXC_VECTOR;
    end

endmodule
